// File: rtl/clock_display_scan.sv
// Six-digit common-anode HH:MM:SS scan driver. Time is snapshotted once per
// frame, split into BCD digits and shown one digit per SCAN_DIV enabled cycles.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          BLANK_LEAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] s,
  input  logic [5:0] m,
  input  logic [4:0] h,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] r_pre;
  logic [2:0]  r_idx;
  logic [5:0]  r_snap_s, r_snap_m;
  logic [4:0]  r_snap_h;
  logic        r_run, r_wrap_d;

  logic        w_tick, w_wrap;
  logic [5:0]  w_val, w_q, w_r;
  logic        w_ok;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg;

  assign w_tick = en && (r_pre == PRE_MAX);
  assign w_wrap = w_tick && (r_idx == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_idx    <= 3'd5;
      r_snap_s <= '0;
      r_snap_m <= '0;
      r_snap_h <= '0;
      r_run    <= 1'b0;
      r_wrap_d <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      if (en) r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
      if (w_tick) begin
        r_run <= 1'b1;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_wrap) begin
        r_snap_s <= s;
        r_snap_m <= m;
        r_snap_h <= h;
      end
    end
  end

  // Field select for the digit currently indexed; odd indices are tens.
  always_comb begin
    w_val = r_snap_s;
    w_ok  = (r_snap_s <= 6'd59);
    case (r_idx)
      3'd2, 3'd3: begin
        w_val = r_snap_m;
        w_ok  = (r_snap_m <= 6'd59);
      end
      3'd4, 3'd5: begin
        w_val = {1'b0, r_snap_h};
        w_ok  = (r_snap_h <= 5'd23);
      end
      default: ;
    endcase
  end

  assign w_q     = w_val / 6'd10;
  assign w_r     = w_val % 6'd10;
  assign w_digit = r_idx[0] ? w_q[3:0] : w_r[3:0];

  always_comb begin
    case (w_digit)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
    // Dash on a bad field wins over the leading-zero blank.
    if (!w_ok)
      w_seg = 7'h3F;
    else if (BLANK_LEAD && r_idx == 3'd5 && w_q == 6'd0)
      w_seg = 7'h7F;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an    <= 6'h3F;
      seg   <= 7'h7F;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= r_run ? ~(6'd1 << r_idx) : 6'h3F;
      seg   <= r_run ? w_seg : 7'h7F;
      dp    <= ~(r_run && (r_idx == 3'd2 || r_idx == 3'd4) && !r_snap_s[0]);
      frame <= r_wrap_d;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: tests push expected digit frames,
// a negedge monitor pops and compares them as each new digit appears.
module tb_clock_display_scan;
  localparam int SD = 4;

  logic       clk, rst_n, en;
  logic [5:0] s, m;
  logic [4:0] h;
  logic [5:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb, frame, frame_nb;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       q[$];
  bit         streaming = 0;
  logic [5:0] prev_an = 6'h3F;

  clock_display_scan #(.SCAN_DIV(SD), .BLANK_LEAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .m(m), .h(h),
    .an(an), .seg(seg), .dp(dp), .frame(frame));

  clock_display_scan #(.SCAN_DIV(SD), .BLANK_LEAD(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .m(m), .h(h),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame(frame_nb));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t mk(int k, int sv, int mv, int hv);
    exp_t e;
    int v, d;
    bit ok;
    v  = (k < 2) ? sv : (k < 4) ? mv : hv;
    ok = (k < 4) ? (v <= 59) : (v <= 23);
    d  = (k % 2 == 1) ? v / 10 : v % 10;
    e.an = 6'h3F;
    e.an[k] = 1'b0;
    if (!ok)                 e.seg = 7'h3F;
    else if (k == 5 && d == 0) e.seg = 7'h7F;
    else                     e.seg = seg_of(d);
    e.dp = !((k == 2 || k == 4) && (sv % 2 == 0));
    return e;
  endfunction

  task automatic push_frame(int sv, int mv, int hv);
    for (int k = 0; k < 6; k++) q.push_back(mk(k, sv, mv, hv));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (an !== prev_an && an !== 6'h3F) begin
      if (!streaming && an === 6'b111110 && q.size() > 0) streaming = 1;
      if (streaming) begin
        e = q.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL scoreboard: got an=%b seg=%h dp=%b, need an=%b seg=%h dp=%b",
                   an, seg, dp, e.an, e.seg, e.dp);
        end
        if (q.size() == 0) streaming = 0;
      end
    end
    prev_an = an;
  end

  task automatic wait_drain(string name);
    int n = 0;
    while ((q.size() > 0 || streaming) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0 || streaming) begin
      errors++;
      $display("FAIL %s drain: %0d entries left, need 0", name, q.size());
      q.delete();
      streaming = 0;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst_n = 0; en = 1; s = 6'd37; m = 6'd5; h = 5'd14;
    repeat (3) @(negedge clk);
    checks++; if (an !== 6'h3F) begin errors++; $display("FAIL reset_an: got %b need 111111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h need 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b need 1", dp); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b need 0", frame); end
    rst_n = 1;
    while (frame !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != SD + 1) begin errors++; $display("FAIL first_frame_latency: got %0d need %0d", n, SD + 1); end
    checks++;
    if (an !== 6'b111110) begin errors++; $display("FAIL first_frame_an: got %b need 111110", an); end
  endtask

  task automatic test_digit_seq();
    int n = 0;
    s = 6'd37; m = 6'd5; h = 5'd14;
    push_frame(37, 5, 14);
    wait_drain("digit_seq");
    while (frame !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    n = 1;
    while (frame !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 6 * SD) begin errors++; $display("FAIL frame_period: got %0d need %0d", n, 6 * SD); end
  endtask

  task automatic test_snapshot();
    int n = 0;
    s = 6'd37; m = 6'd5; h = 5'd14;
    push_frame(37, 5, 14);
    push_frame(38, 5, 14);
    while (!(streaming && an === 6'b110111) && n < 200) begin @(negedge clk); n++; end
    s = 6'd38;
    wait_drain("snapshot");
  endtask

  task automatic test_lead_blank();
    int n = 0;
    s = 6'd38; m = 6'd5; h = 5'd7;
    push_frame(38, 5, 7);
    wait_drain("blank_h7");
    while (an_nb !== 6'b011111 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (seg_nb !== 7'h40) begin errors++; $display("FAIL noblank_h7: got %h need 40", seg_nb); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL blank_h7_live: got %h need 7f", seg); end
    h = 5'd0;
    push_frame(38, 5, 0);
    wait_drain("blank_h0");
  endtask

  task automatic test_out_of_range();
    s = 6'd60; m = 6'd5; h = 5'd14;
    push_frame(60, 5, 14);
    wait_drain("range_s60");
    s = 6'd21; h = 5'd24;
    push_frame(21, 5, 24);
    wait_drain("range_h24");
    h = 5'd14;
  endtask

  task automatic test_enable_hold();
    logic [5:0] a0;
    logic [6:0] s0;
    logic       d0;
    int n = 0;
    bit bad = 0;
    s = 6'd40; m = 6'd5; h = 5'd14;
    while (!(an === 6'b111011 && prev_an !== 6'b111011) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    a0 = an; s0 = seg; d0 = dp;
    en = 0;
    repeat (50) begin
      @(negedge clk);
      if (an !== a0 || seg !== s0 || dp !== d0 || frame !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL en_hold: outputs moved, now an=%b seg=%h dp=%b need an=%b seg=%h dp=%b", an, seg, dp, a0, s0, d0); end
    en = 1;
    n = 0;
    while (an === a0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != SD - 1) begin errors++; $display("FAIL en_resume_dwell: got %0d need %0d", n, SD - 1); end
  endtask

  task automatic test_reset_midscan();
    repeat (7) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({an, seg, dp, frame} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midscan_reset: got an=%b seg=%h dp=%b frame=%b need 111111 7f 1 0", an, seg, dp, frame);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_digit_seq();
    test_snapshot();
    test_lead_blank();
    test_out_of_range();
    test_enable_hold();
    test_reset_midscan();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
